warp_scheduler: RTL and testbench

- Multi-warp successor to the single-block core scheduler.
- Tracks NUM_WARPS independent warps, each with its own PC and state.
- Selects one READY warp per cycle round-robin and issues it to the shared fetch/decode/execute pipeline over a valid/ready handshake.
- Parks a warp while its memory operation is outstanding, so other warps hide the memory latency.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/warp_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_warp_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared state encodings for the warp scheduler and its helpers.
package gpu_pkg;

    typedef enum logic [2:0] {
        WS_IDLE,
        WS_READY,
        WS_ISSUED,
        WS_WAIT_MEM,
        WS_FINISHED
    } warp_state_t;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_RUN,
        CS_DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping to the
// lowest index, and returns a one-hot grant plus the granted index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo-N wrap that also holds for non-power-of-two N.
            sum  = {1'b0, ptr} + (IW+1)'(k);
            cand = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp scheduler: per-warp state/PC contexts, a round-robin issue
// register toward the shared pipeline, memory-latency parking and a stall counter.
module warp_scheduler
    import gpu_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int START_PC   = 0,
    parameter int PERF_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(NUM_WARPS):0]   warp_count,
    output logic                         issue_valid,
    output logic [$clog2(NUM_WARPS)-1:0] issue_warp,
    output logic [ADDR_WIDTH-1:0]        issue_pc,
    input  logic                         issue_ready,
    input  logic                         complete_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] complete_warp,
    input  logic [ADDR_WIDTH-1:0]        complete_next_pc,
    input  logic                         complete_mem,
    input  logic                         complete_ret,
    input  logic                         mem_done_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] mem_done_warp,
    output logic [NUM_WARPS-1:0]         active_mask,
    output logic                         done,
    output logic                         err,
    output logic [PERF_WIDTH-1:0]        stall_cycles
);

    localparam int WW = $clog2(NUM_WARPS);
    localparam int CW = WW + 1;
    localparam logic [CW-1:0]         NUM_WARPS_C = CW'(NUM_WARPS);
    localparam logic [ADDR_WIDTH-1:0] START_PC_V  = ADDR_WIDTH'(START_PC);

    sched_state_t          core_state_q, core_state_d;
    warp_state_t           warp_state_q [NUM_WARPS];
    warp_state_t           warp_state_d [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] warp_pc_q    [NUM_WARPS];
    logic [ADDR_WIDTH-1:0] warp_pc_d    [NUM_WARPS];
    logic [NUM_WARPS-1:0]  enabled_q, enabled_d;
    logic                  issue_valid_q, issue_valid_d;
    logic [WW-1:0]         issue_warp_q, issue_warp_d;
    logic [ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;
    logic [WW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  err_q, err_d;
    logic [PERF_WIDTH-1:0] stall_q, stall_d;

    logic [CW-1:0]        count_clamped;
    logic [NUM_WARPS-1:0] launch_mask;
    logic [NUM_WARPS-1:0] arb_req;
    logic [NUM_WARPS-1:0] arb_grant;
    logic [WW-1:0]        arb_idx;
    logic                 arb_any;
    logic                 cmp_legal;
    logic                 mem_legal;
    logic                 busy;

    assign count_clamped = (warp_count > NUM_WARPS_C) ? NUM_WARPS_C : warp_count;
    assign arb_any       = |arb_grant;

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            assign launch_mask[gi] = (CW'(gi) < count_clamped);
            assign arb_req[gi]     = (core_state_q == CS_RUN) && (warp_state_q[gi] == WS_READY);
            assign active_mask[gi] = (core_state_q != CS_IDLE) && enabled_q[gi]
                                     && (warp_state_q[gi] != WS_FINISHED);
        end
    endgenerate

    rr_arbiter #(
        .N  (NUM_WARPS),
        .IW (WW)
    ) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        core_state_d  = core_state_q;
        warp_state_d  = warp_state_q;
        warp_pc_d     = warp_pc_q;
        enabled_d     = enabled_q;
        issue_valid_d = issue_valid_q;
        issue_warp_d  = issue_warp_q;
        issue_pc_d    = issue_pc_q;
        rr_ptr_d      = rr_ptr_q;
        err_d         = err_q;
        stall_d       = stall_q;
        cmp_legal     = 1'b0;
        mem_legal     = 1'b0;
        busy          = 1'b0;

        // Pipeline events only act on a warp in the matching state; anything else is flagged.
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (complete_valid && complete_warp == WW'(i) && warp_state_q[i] == WS_ISSUED) begin
                cmp_legal = 1'b1;
                if (complete_ret) begin
                    warp_state_d[i] = WS_FINISHED;
                end else begin
                    warp_state_d[i] = complete_mem ? WS_WAIT_MEM : WS_READY;
                    warp_pc_d[i]    = complete_next_pc;
                end
            end
            if (mem_done_valid && mem_done_warp == WW'(i) && warp_state_q[i] == WS_WAIT_MEM) begin
                mem_legal       = 1'b1;
                warp_state_d[i] = WS_READY;
            end
            if (enabled_q[i] && (warp_state_q[i] inside {WS_READY, WS_ISSUED, WS_WAIT_MEM})) begin
                busy = 1'b1;
            end
        end
        if ((complete_valid && !cmp_legal) || (mem_done_valid && !mem_legal)) begin
            err_d = 1'b1;
        end

        case (core_state_q)
            CS_IDLE: begin
                if (start) begin
                    core_state_d = CS_RUN;
                    err_d        = 1'b0;
                    stall_d      = '0;
                    enabled_d    = launch_mask;
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        warp_state_d[i] = launch_mask[i] ? WS_READY : WS_IDLE;
                        if (launch_mask[i]) begin
                            warp_pc_d[i] = START_PC_V;
                        end
                    end
                end
            end
            CS_RUN: begin
                if (!issue_valid_q && stall_q != '1) begin
                    stall_d = stall_q + 1'b1;
                end
                // Refill when empty or when the held entry is being taken this cycle.
                if (!issue_valid_q || issue_ready) begin
                    issue_valid_d = arb_any;
                    if (arb_any) begin
                        issue_warp_d = arb_idx;
                        rr_ptr_d     = (arb_idx == WW'(NUM_WARPS - 1)) ? '0 : arb_idx + 1'b1;
                        for (int i = 0; i < NUM_WARPS; i++) begin
                            if (arb_grant[i]) begin
                                warp_state_d[i] = WS_ISSUED;
                                issue_pc_d      = warp_pc_q[i];
                            end
                        end
                    end
                end
                if (!busy && !issue_valid_q) begin
                    core_state_d = CS_DONE;
                end
            end
            CS_DONE: begin
                if (!start) begin
                    core_state_d = CS_IDLE;
                end
            end
            default: core_state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state_q  <= CS_IDLE;
            for (int i = 0; i < NUM_WARPS; i++) begin
                warp_state_q[i] <= WS_IDLE;
                warp_pc_q[i]    <= '0;
            end
            enabled_q     <= '0;
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
            issue_pc_q    <= '0;
            rr_ptr_q      <= '0;
            err_q         <= 1'b0;
            stall_q       <= '0;
        end else begin
            core_state_q  <= core_state_d;
            warp_state_q  <= warp_state_d;
            warp_pc_q     <= warp_pc_d;
            enabled_q     <= enabled_d;
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
            issue_pc_q    <= issue_pc_d;
            rr_ptr_q      <= rr_ptr_d;
            err_q         <= err_d;
            stall_q       <= stall_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_warp   = issue_warp_q;
    assign issue_pc     = issue_pc_q;
    assign done         = (core_state_q == CS_DONE);
    assign err          = err_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized bench for warp_scheduler: a behavioural model of the warp rules plus
// a fake pipeline/memory that returns completions for accepted issues.
module tb_warp_scheduler;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int PW = 6;
    localparam int WW = 2;
    localparam int CW = 3;
    localparam int MAXS = (1 << PW) - 1;

    localparam int ST_IDLE = 0, ST_READY = 1, ST_ISSUED = 2, ST_WAIT = 3, ST_FIN = 4;
    localparam int C_IDLE = 0, C_RUN = 1, C_DONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] warp_count = '0;
    logic          issue_valid;
    logic [WW-1:0] issue_warp;
    logic [AW-1:0] issue_pc;
    logic          issue_ready = 1'b0;
    logic          complete_valid = 1'b0;
    logic [WW-1:0] complete_warp = '0;
    logic [AW-1:0] complete_next_pc = '0;
    logic          complete_mem = 1'b0;
    logic          complete_ret = 1'b0;
    logic          mem_done_valid = 1'b0;
    logic [WW-1:0] mem_done_warp = '0;
    logic [N-1:0]  active_mask;
    logic          done;
    logic          err;
    logic [PW-1:0] stall_cycles;

    warp_scheduler #(
        .NUM_WARPS  (N),
        .ADDR_WIDTH (AW),
        .START_PC   (0),
        .PERF_WIDTH (PW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .warp_count       (warp_count),
        .issue_valid      (issue_valid),
        .issue_warp       (issue_warp),
        .issue_pc         (issue_pc),
        .issue_ready      (issue_ready),
        .complete_valid   (complete_valid),
        .complete_warp    (complete_warp),
        .complete_next_pc (complete_next_pc),
        .complete_mem     (complete_mem),
        .complete_ret     (complete_ret),
        .mem_done_valid   (mem_done_valid),
        .mem_done_warp    (mem_done_warp),
        .active_mask      (active_mask),
        .done             (done),
        .err              (err),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_core;
    int m_ws [N];
    int m_pc [N];
    bit m_en [N];
    bit m_iv;
    int m_iw;
    int m_ipc;
    int m_ptr;
    bit m_err;
    int m_stall;
    int acc_q[$];
    int mem_q[$];
    int pend_mem = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_core = C_IDLE;
        for (int i = 0; i < N; i++) begin
            m_ws[i] = ST_IDLE;
            m_pc[i] = 0;
            m_en[i] = 1'b0;
        end
        m_iv = 1'b0; m_iw = 0; m_ipc = 0; m_ptr = 0; m_err = 1'b0; m_stall = 0;
        acc_q.delete();
    endtask

    task automatic model_step();
        int ows [N];
        int opc [N];
        bit oiv;
        bit busy;
        int w;
        int n;
        ows = m_ws;
        opc = m_pc;
        oiv = m_iv;
        if (oiv && issue_ready) acc_q.push_back(m_iw);
        if (complete_valid) begin
            w = int'(complete_warp);
            if (ows[w] == ST_ISSUED) begin
                if (complete_ret) m_ws[w] = ST_FIN;
                else begin
                    m_ws[w] = complete_mem ? ST_WAIT : ST_READY;
                    m_pc[w] = int'(complete_next_pc);
                end
            end else m_err = 1'b1;
        end
        if (mem_done_valid) begin
            w = int'(mem_done_warp);
            if (ows[w] == ST_WAIT) m_ws[w] = ST_READY;
            else m_err = 1'b1;
        end
        case (m_core)
            C_IDLE: if (start) begin
                n = (int'(warp_count) > N) ? N : int'(warp_count);
                m_core = C_RUN; m_err = 1'b0; m_stall = 0;
                for (int i = 0; i < N; i++) begin
                    m_en[i] = (i < n);
                    m_ws[i] = m_en[i] ? ST_READY : ST_IDLE;
                    if (m_en[i]) m_pc[i] = 0;
                end
            end
            C_RUN: begin
                if (!oiv) m_stall = (m_stall == MAXS) ? MAXS : m_stall + 1;
                if (!oiv || issue_ready) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && ows[(m_ptr + k) % N] == ST_READY) w = (m_ptr + k) % N;
                    if (w >= 0) begin
                        m_iv = 1'b1; m_iw = w; m_ipc = opc[w];
                        m_ws[w] = ST_ISSUED; m_ptr = (w + 1) % N;
                    end else m_iv = 1'b0;
                end
                busy = 1'b0;
                for (int i = 0; i < N; i++)
                    if (m_en[i] && (ows[i] == ST_READY || ows[i] == ST_ISSUED || ows[i] == ST_WAIT)) busy = 1'b1;
                if (!busy && !oiv) m_core = C_DONE;
            end
            default: if (!start) m_core = C_IDLE;
        endcase
    endtask

    function automatic int exp_mask();
        int m = 0;
        for (int i = 0; i < N; i++)
            if (m_core != C_IDLE && m_en[i] && m_ws[i] != ST_FIN) m = m | (1 << i);
        return m;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        if (m_iv) begin
            chk("issue_warp", 32'(issue_warp), 32'(m_iw));
            chk("issue_pc", 32'(issue_pc), 32'(m_ipc));
        end
        chk("active_mask", 32'(active_mask), 32'(exp_mask()));
        chk("done", 32'(done), 32'(m_core == C_DONE));
        chk("err", 32'(err), 32'(m_err));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        complete_valid = 1'b0; complete_ret = 1'b0; complete_mem = 1'b0;
        mem_done_valid = 1'b0;
    endtask

    task automatic run_random(input int count, input bit do_rst);
        int cyc, k, w, r, rdy_pct, cmp_pct, mem_pct;
        acc_q.delete(); mem_q.delete(); pend_mem = -1;
        rdy_pct = $urandom_range(100, 40);
        cmp_pct = $urandom_range(80, 8);
        mem_pct = $urandom_range(80, 10);
        warp_count = CW'(count);
        if (m_core == C_IDLE) start = 1'b1;
        cyc = 0;
        while (m_core != C_DONE && cyc < 3000) begin
            quiet();
            if (pend_mem >= 0) begin mem_q.push_back(pend_mem); pend_mem = -1; end
            issue_ready = ($urandom_range(99) < rdy_pct);
            if (mem_q.size() > 0 && $urandom_range(99) < mem_pct) begin
                k = $urandom_range(mem_q.size() - 1);
                mem_done_valid = 1'b1; mem_done_warp = WW'(mem_q[k]);
                mem_q.delete(k);
            end else if ($urandom_range(99) < 2) begin
                mem_done_valid = 1'b1; mem_done_warp = WW'($urandom_range(N - 1));
            end
            if (acc_q.size() > 0 && $urandom_range(99) < cmp_pct) begin
                k = $urandom_range(acc_q.size() - 1);
                w = acc_q[k];
                acc_q.delete(k);
                complete_valid = 1'b1; complete_warp = WW'(w);
                complete_next_pc = AW'($urandom);
                r = $urandom_range(99);
                if (r < 20) complete_ret = 1'b1;
                else if (r < 50) begin complete_mem = 1'b1; pend_mem = w; end
            end else if ($urandom_range(99) < 3) begin
                complete_valid = 1'b1; complete_warp = WW'($urandom_range(N - 1));
                complete_next_pc = AW'($urandom);
            end
            if (m_core != C_IDLE && $urandom_range(3) == 0) start = 1'b0;
            tick();
            cyc++;
            if (do_rst && cyc >= 8 && m_iv) begin
                quiet(); start = 1'b0; rst = 1'b1;
                tick();
                chk("rst_issue_valid", 32'(issue_valid), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_active_mask", 32'(active_mask), 0);
                chk("rst_stall", 32'(stall_cycles), 0);
                rst = 1'b0;
                return;
            end
        end
        if (m_core != C_DONE) begin
            n_cmp++; n_fail++;
            $display("FAIL run_timeout: got core %0d expected DONE within 3000 cycles", m_core);
        end
        quiet(); start = 1'b0;
        tick();
        chk("done_release", 32'(done), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        tick();
        chk("reset_valid", 32'(issue_valid), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        rst = 1'b0;

        // Launch three warps with the pipeline always ready.
        warp_count = 3'd3; start = 1'b1; issue_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("launch_w0_valid", 32'(issue_valid), 1);
        chk("launch_w0", 32'(issue_warp), 0);
        chk("launch_w0_pc", 32'(issue_pc), 0);
        chk("launch_stall", 32'(stall_cycles), 1);
        tick();
        chk("launch_w1", 32'(issue_warp), 1);
        tick();
        chk("launch_w2", 32'(issue_warp), 2);
        tick();
        chk("launch_drain", 32'(issue_valid), 0);
        chk("launch_mask", 32'(active_mask), 32'h7);

        // Legal complete makes warp 1 READY, then an illegal one hits it while READY.
        complete_valid = 1'b1; complete_warp = 2'd1; complete_next_pc = 8'd9;
        tick();
        complete_ret = 1'b1; complete_next_pc = 8'h33; issue_ready = 1'b0;
        tick();
        quiet();
        chk("err_set", 32'(err), 1);
        chk("err_w1_issued", 32'(issue_warp), 1);
        chk("err_w1_pc", 32'(issue_pc), 9);
        chk("err_mask", 32'(active_mask), 32'h7);
        tick();
        chk("hold_warp", 32'(issue_warp), 1);
        chk("hold_pc", 32'(issue_pc), 9);
        issue_ready = 1'b1;
        tick();

        // Retire all three warps.
        for (int i = 0; i < 3; i++) begin
            complete_valid = 1'b1; complete_ret = 1'b1; complete_warp = WW'(i);
            tick();
        end
        quiet();
        tick();
        chk("finish_done", 32'(done), 1);
        chk("finish_mask", 32'(active_mask), 0);
        tick();
        chk("finish_release", 32'(done), 0);
        chk("err_sticky", 32'(err), 1);

        warp_count = 3'd4; start = 1'b1;
        tick();
        chk("err_clear", 32'(err), 0);
        start = 1'b0;
        run_random(4, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_random($urandom_range(7), r == 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
